// File: rtl/tmds_decoder.sv
// DVI TMDS channel decoder: hunts control tokens across 10 bit-slip offsets, then decodes symbols.
// Aligned word to outputs is two register stages; no backpressure, one symbol accepted every pixel clock.
module tmds_decoder #(
  parameter int LOCK_COUNT   = 8,
  parameter int SEARCH_LIMIT = 2048,
  parameter int CNT_W        = 12
) (
  input  logic       i_pixclk,
  input  logic       i_reset_n,
  input  logic [9:0] i_raw,
  output logic [7:0] o_data,
  output logic       o_de,
  output logic [1:0] o_ctrl,
  output logic       o_locked,
  output logic [3:0] o_offset
);
  localparam int TOK_W = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] GAP_MAX = CNT_W'(SEARCH_LIMIT - 1);
  localparam logic [TOK_W-1:0] TOK_MAX = TOK_W'(LOCK_COUNT - 1);

  typedef enum logic {SEARCH, LOCKED} state_t;

  state_t           state_q, state_d;
  logic [3:0]       offset_q, offset_d;
  logic [TOK_W-1:0] tok_cnt_q, tok_cnt_d;
  logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [9:0]       prev_q, w_q, w_d;
  logic [19:0]      cat;
  logic             is_tok;
  logic [1:0]       tok_val;
  logic [7:0]       sym, dec;
  logic [7:0]       data_q, data_d;
  logic             de_q, de_d;
  logic [1:0]       ctrl_q, ctrl_d;

  // Bit 0 of the concatenation is the oldest received bit.
  assign cat = {i_raw, prev_q};

  always_comb begin
    w_d = cat[9:0];
    for (int k = 1; k < 10; k++) begin
      if (offset_q == 4'(k)) w_d = cat[k +: 10];
    end
  end

  always_comb begin
    is_tok  = 1'b1;
    tok_val = 2'd0;
    case (w_q)
      10'h354: tok_val = 2'd0;
      10'h0AB: tok_val = 2'd1;
      10'h154: tok_val = 2'd2;
      10'h2AB: tok_val = 2'd3;
      default: is_tok  = 1'b0;
    endcase
  end

  always_comb begin
    sym    = w_q[9] ? ~w_q[7:0] : w_q[7:0];
    dec    = '0;
    dec[0] = sym[0];
    for (int i = 1; i < 8; i++) begin
      dec[i] = w_q[8] ? (sym[i] ^ sym[i-1]) : ~(sym[i] ^ sym[i-1]);
    end
  end

  always_ff @(posedge i_pixclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= SEARCH;
      offset_q  <= '0;
      tok_cnt_q <= '0;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      offset_q  <= offset_d;
      tok_cnt_q <= tok_cnt_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    offset_d  = offset_q;
    tok_cnt_d = tok_cnt_q;
    gap_cnt_d = gap_cnt_q;
    if (is_tok) begin
      gap_cnt_d = '0;
      if (state_q == SEARCH) begin
        if (tok_cnt_q == TOK_MAX) begin
          state_d   = LOCKED;
          tok_cnt_d = '0;
        end else begin
          tok_cnt_d = tok_cnt_q + 1'b1;
        end
      end
    end else begin
      tok_cnt_d = '0;
      if (gap_cnt_q == GAP_MAX) begin
        gap_cnt_d = '0;
        // A locked link keeps its offset when it falls back to hunting.
        if (state_q == LOCKED) state_d  = SEARCH;
        else                   offset_d = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;
      end else begin
        gap_cnt_d = gap_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    data_d = '0;
    de_d   = 1'b0;
    ctrl_d = ctrl_q;
    if (state_q == LOCKED) begin
      if (is_tok) begin
        ctrl_d = tok_val;
      end else begin
        de_d   = 1'b1;
        data_d = dec;
      end
    end
  end

  always_ff @(posedge i_pixclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      prev_q <= '0;
      w_q    <= '0;
      data_q <= '0;
      de_q   <= 1'b0;
      ctrl_q <= '0;
    end else begin
      prev_q <= i_raw;
      w_q    <= w_d;
      data_q <= data_d;
      de_q   <= de_d;
      ctrl_q <= ctrl_d;
    end
  end

  assign o_data   = data_q;
  assign o_de     = de_q;
  assign o_ctrl   = ctrl_q;
  assign o_locked = (state_q == LOCKED);
  assign o_offset = offset_q;
endmodule
